sys_decode: RTL and testbench

Decode stage for SYSTEM-class instructions, directly upstream of the execute stage. Accepts fetched `{pc, instruction}` pairs over a valid/ready handshake and decodes opcode 0x73 (ECALL, EBREAK, MRET, WFI, optionally Zicsr). It presents the registered `pc` and `sys_ops` bundle to execute through a 2-entry skid buffer. Once a trap-class instruction (ebreak, ecall, illegal) has been accepted, the block stops taking new instructions until flushed.

---
 rtl/sys_pkg.sv | 76 +++++++
 rtl/sys_ops_if.sv | 34 +++
 rtl/sys_skid_buf.sv | 73 +++++++
 rtl/sys_decode.sv | 93 +++++++++
 tb/tb_sys_decode.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sys_pkg.sv
// sys_pkg: shared constants, types and the SYSTEM-class decode function.
// CSR fields of sys_dec_t exist only when SYS_CSR_EN is defined.
package sys_pkg;

  localparam logic [6:0]  OP_SYSTEM   = 7'h73;
  localparam logic [31:0] INSN_ECALL  = 32'h00000073;
  localparam logic [31:0] INSN_EBREAK = 32'h00100073;
  localparam logic [31:0] INSN_MRET   = 32'h30200073;
  localparam logic [31:0] INSN_WFI    = 32'h10500073;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } dec_state_t;

  typedef struct packed {
    logic        ebreak;
    logic        ecall;
    logic        mret;
    logic        wfi;
    logic        illegal;
`ifdef SYS_CSR_EN
    csr_op_t     csr_op;
    logic        csr_imm;
    logic [11:0] csr_addr;
    logic [4:0]  csr_rd;
    logic [4:0]  csr_src;
`endif
  } sys_dec_t;

  function automatic sys_dec_t sys_dec(input logic [31:0] insn);
    sys_dec_t d;
    logic     sys;
`ifdef SYS_CSR_EN
    logic [2:0] f3;
    f3 = insn[14:12];
`endif
    d   = '0;
    sys = (insn[6:0] == OP_SYSTEM);
    unique case (1'b1)
      insn[1:0] != 2'b11:
        d.illegal = 1'b1;
      insn[1:0] == 2'b11 && !sys:
        d = '0;
      insn == INSN_ECALL:
        d.ecall = 1'b1;
      insn == INSN_EBREAK:
        d.ebreak = 1'b1;
      insn == INSN_MRET:
        d.mret = 1'b1;
      insn == INSN_WFI:
        d.wfi = 1'b1;
`ifdef SYS_CSR_EN
      // funct3 bit 2 selects the zimm form; low bits map onto csr_op_t
      sys && f3 != 3'b000 && f3 != 3'b100: begin
        d.csr_op   = csr_op_t'(f3[1:0]);
        d.csr_imm  = f3[2];
        d.csr_addr = insn[31:20];
        d.csr_rd   = insn[11:7];
        d.csr_src  = insn[19:15];
      end
`endif
      default:
        d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sys_ops_if.sv
// sys_ops_if: decoded SYSTEM-op bundle from decode to execute.
// CSR fields are present only when SYS_CSR_EN is defined.
interface sys_ops_if;
  import sys_pkg::*;

  logic ebreak_op;
  logic ecall_op;
  logic mret_op;
  logic wfi_op;
`ifdef SYS_CSR_EN
  csr_op_t     csr_op;
  logic        csr_imm;
  logic [11:0] csr_addr;
  logic [4:0]  csr_rd;
  logic [4:0]  csr_src;

  modport src (
    output ebreak_op, ecall_op, mret_op, wfi_op,
    output csr_op, csr_imm, csr_addr, csr_rd, csr_src
  );
  modport dst (
    input ebreak_op, ecall_op, mret_op, wfi_op,
    input csr_op, csr_imm, csr_addr, csr_rd, csr_src
  );
`else
  modport src (
    output ebreak_op, ecall_op, mret_op, wfi_op
  );
  modport dst (
    input ebreak_op, ecall_op, mret_op, wfi_op
  );
`endif

endinterface

// File: rtl/sys_skid_buf.sv
// sys_skid_buf: 2-entry skid buffer; entry 0 drives the output,
// entry 1 absorbs one extra word under backpressure.
module sys_skid_buf #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data,
  output logic full_d
);

  logic v0_q, v0_d;
  logic v1_q, v1_d;
  T     d0_q, d0_d;
  T     d1_q, d1_d;
  logic pop;
  logic free0;

  always_comb begin
    v0_d  = v0_q;
    v1_d  = v1_q;
    d0_d  = d0_q;
    d1_d  = d1_q;
    pop   = v0_q && out_ready;
    free0 = pop || !v0_q;
    unique case (1'b1)
      flush: begin
        v0_d = 1'b0;
        v1_d = 1'b0;
      end
      !flush && free0 && v1_q: begin
        v0_d = 1'b1;
        d0_d = d1_q;
        v1_d = in_valid;
        if (in_valid) d1_d = in_data;
      end
      !flush && free0 && !v1_q: begin
        v0_d = in_valid;
        if (in_valid) d0_d = in_data;
      end
      default: begin
        if (in_valid) begin
          v1_d = 1'b1;
          d1_d = in_data;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      d0_q <= '0;
      d1_q <= '0;
    end else begin
      v0_q <= v0_d;
      v1_q <= v1_d;
      d0_q <= d0_d;
      d1_q <= d1_d;
    end
  end

  assign out_valid = v0_q;
  assign out_data  = d0_q;
  assign full_d    = v1_d;

endmodule

// File: rtl/sys_decode.sv
// sys_decode: SYSTEM-class decode stage with skid-buffered output.
// Define SYS_CSR_EN to decode Zicsr forms instead of trapping them.
module sys_decode
  import sys_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_insn,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc,
  output logic            illegal,
  sys_ops_if.src          sys_ops
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    sys_dec_t        dec;
  } entry_t;

  dec_state_t state_q, state_d;
  logic       rdy_q, rdy_d;
  logic       accept;
  logic       trap;
  logic       skid_full_d;
  sys_dec_t   dec;
  entry_t     in_e;
  entry_t     out_e;

  always_comb begin
    dec      = sys_dec(in_insn);
    in_e.pc  = in_pc;
    in_e.dec = dec;
    accept   = in_valid && rdy_q;
    trap     = dec.ebreak || dec.ecall || dec.illegal;
    state_d  = state_q;
    unique case (1'b1)
      flush:
        state_d = RUN;
      !flush && accept && trap:
        state_d = HALT;
      default: ;
    endcase
    // ready is registered from next-state so a full skid blocks the very next cycle
    rdy_d = !skid_full_d && (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
    end
  end

  sys_skid_buf #(
    .T(entry_t)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (accept),
    .in_data   (in_e),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_e),
    .full_d    (skid_full_d)
  );

  assign in_ready          = rdy_q;
  assign pc                = out_e.pc;
  assign illegal           = out_e.dec.illegal;
  assign sys_ops.ebreak_op = out_e.dec.ebreak;
  assign sys_ops.ecall_op  = out_e.dec.ecall;
  assign sys_ops.mret_op   = out_e.dec.mret;
  assign sys_ops.wfi_op    = out_e.dec.wfi;
`ifdef SYS_CSR_EN
  assign sys_ops.csr_op    = out_e.dec.csr_op;
  assign sys_ops.csr_imm   = out_e.dec.csr_imm;
  assign sys_ops.csr_addr  = out_e.dec.csr_addr;
  assign sys_ops.csr_rd    = out_e.dec.csr_rd;
  assign sys_ops.csr_src   = out_e.dec.csr_src;
`endif

endmodule

// File: tb/tb_sys_decode.sv
// tb_sys_decode: scoreboard bench for sys_decode.
// Honors SYS_CSR_EN the same way the design does.
module tb_sys_decode;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ops;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pc = '0;
  logic [31:0] in_insn = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] pc;
  logic        illegal;

  sys_ops_if ops ();

  sys_decode #(.XLEN(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_insn   (in_insn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pc        (pc),
    .illegal   (illegal),
    .sys_ops   (ops)
  );

  always #5 clk = ~clk;

  int   n_err = 0;
  int   n_chk = 0;
  exp_t q[$];
  logic live = 1'b0;
  logic halted = 1'b0;
  logic exp_rdy = 1'b0;
  logic acc = 1'b0;
  int   idx;

  logic [31:0] words [12] = '{
    32'h00000013, 32'h00500093, 32'h30200073, 32'h10500073,
    32'h00000013, 32'h34202573, 32'h300110F3, 32'h0010D073,
    32'h00100073, 32'h00000073, 32'h00200073, 32'h00000012
  };

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // bit layout: [4]=ebreak [3]=ecall [2]=mret [1]=wfi [0]=illegal,
  // [6:5]=csr_op [7]=csr_imm [19:8]=csr_addr [24:20]=csr_rd [29:25]=csr_src
  function automatic logic [31:0] model_ops(input logic [31:0] w);
    logic [31:0] o;
    logic [2:0]  f3;
    o  = '0;
    f3 = w[14:12];
    if (w[1:0] != 2'b11) o[0] = 1'b1;
    else if (w[6:0] == 7'h73) begin
      if (w == 32'h00100073) o[4] = 1'b1;
      else if (w == 32'h00000073) o[3] = 1'b1;
      else if (w == 32'h30200073) o[2] = 1'b1;
      else if (w == 32'h10500073) o[1] = 1'b1;
`ifdef SYS_CSR_EN
      else if (f3 != 3'd0 && f3 != 3'd4)
        o[29:5] = {w[19:15], w[11:7], w[31:20], f3[2], f3[1:0]};
`endif
      else o[0] = 1'b1;
    end
    return o;
  endfunction

  function automatic logic [31:0] got_ops();
    logic [31:0] o;
    o = '0;
    o[4:0] = {ops.ebreak_op, ops.ecall_op, ops.mret_op,
              ops.wfi_op, illegal};
`ifdef SYS_CSR_EN
    o[29:5] = {ops.csr_src, ops.csr_rd, ops.csr_addr,
               ops.csr_imm, ops.csr_op};
`endif
    return o;
  endfunction

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (live) begin
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, q.size() != 0);
      if (out_valid && q.size() != 0) begin
        check("sb_pc", pc, q[0].pc);
        check("sb_ops", got_ops(), q[0].ops);
      end
    end
    acc = live && !rst && in_valid && in_ready;
    if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
    if (rst || flush) begin
      q.delete();
      halted = 1'b0;
    end else if (acc) begin
      e.pc  = in_pc;
      e.ops = model_ops(in_insn);
      q.push_back(e);
      if (e.ops[4] || e.ops[3] || e.ops[0]) halted = 1'b1;
    end
    exp_rdy = !rst && q.size() < 2 && !halted;
    if (rst) live = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cycle();
    check("rst_rdy", in_ready, 0);
    check("rst_vld", out_valid, 0);
    check("rst_pc", pc, 0);
    cycle();
    rst = 1'b0;
    cycle();
    check("post_rst_rdy", in_ready, 1);
    check("post_rst_vld", out_valid, 0);
    check("post_rst_ops", got_ops(), 0);

    // ebreak halts; output holds under backpressure
    in_valid = 1'b1;
    in_pc    = 64'h80000000;
    in_insn  = 32'h00100073;
    cycle();
    in_valid = 1'b0;
    check("ebk_vld", out_valid, 1);
    check("ebk_op", ops.ebreak_op, 1);
    check("ebk_pc", pc, 64'h80000000);
    check("ebk_halt", in_ready, 0);
    cycle();
    check("ebk_hold_pc", pc, 64'h80000000);
    out_ready = 1'b1;
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_rdy", in_ready, 1);

    // streaming at full rate
    in_valid = 1'b1;
    in_pc = 64'h100; in_insn = 32'h30200073;
    cycle();
    check("mret_op", ops.mret_op, 1);
    check("stream_rdy0", in_ready, 1);
    in_pc = 64'h104; in_insn = 32'h10500073;
    cycle();
    check("wfi_op", ops.wfi_op, 1);
    check("stream_rdy1", in_ready, 1);
    in_pc = 64'h108; in_insn = 32'h00000013;
    cycle();
    check("nop_ops", got_ops(), 0);
    check("nop_vld", out_valid, 1);
    check("stream_rdy2", in_ready, 1);
    in_valid = 1'b0;
    cycle();
    cycle();

    // backpressure fills both entries then stalls
    out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pc    = 64'h1000 + 64'(idx * 4);
      in_insn  = 32'h00000093 | (32'(idx + 1) << 20);
      cycle();
      if (acc) idx++;
    end
    check("bp_acc", idx, 2);
    check("bp_rdy", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && idx < 4; i++) begin
      in_pc   = 64'h1000 + 64'(idx * 4);
      in_insn = 32'h00000093 | (32'(idx + 1) << 20);
      cycle();
      if (acc) idx++;
    end
    check("bp_all", idx, 4);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("bp_drain", q.size(), 0);

    // undefined SYSTEM word, then flush against a pending fetch
    in_valid = 1'b1;
    in_pc = 64'h200; in_insn = 32'h00200073;
    cycle();
    check("ill_flag", illegal, 1);
    check("ill_halt", in_ready, 0);
    in_insn = 32'h00000013;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("ill_flush_vld", out_valid, 0);
    check("ill_flush_rdy", in_ready, 1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_drop", out_valid, 0);

    // csrrw x1, mstatus, x2
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_pc = 64'h300; in_insn = 32'h300110F3;
    cycle();
    in_valid = 1'b0;
`ifdef SYS_CSR_EN
    check("csr_op", ops.csr_op, 1);
    check("csr_addr", ops.csr_addr, 12'h300);
    check("csr_rd", ops.csr_rd, 1);
    check("csr_src", ops.csr_src, 2);
    check("csr_imm", ops.csr_imm, 0);
    check("csr_ill", illegal, 0);
`else
    check("csr_ill", illegal, 1);
    check("csr_halt", in_ready, 0);
`endif
    out_ready = 1'b1;
    flush = 1'b1;
    cycle();
    flush = 1'b0;

    // reset with both entries full
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_pc = 64'h400; in_insn = 32'h00000013;
    cycle();
    in_pc = 64'h404;
    cycle();
    in_valid = 1'b0;
    check("full_rdy", in_ready, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_vld", out_valid, 0);
    check("mid_rst_pc", pc, 0);
    check("mid_rst_ops", got_ops(), 0);
    cycle();
    check("mid_rst_rdy", in_ready, 1);

    // random traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      in_insn   = words[$urandom_range(0, 11)];
      in_pc     = 64'h2000 + 64'(i * 4);
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 7) == 0;
      cycle();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check("final_drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
